// File: rtl/dmem_access_pkg.sv
// Shared CPU types for the MEM stage: word type, decoded operations and
// bus transfer-size encodings, plus small decode helpers.
package dmem_access_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLT,
    OP_SLL,
    OP_BEQ,
    OP_J,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_SB,
    OP_SH,
    OP_SW
  } decoded_op_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic is_mem_op(input decoded_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
      OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
      default:             is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input decoded_op_t op);
    case (op)
      OP_SB, OP_SH, OP_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input decoded_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
      default:              op_size = SIZE_WORD;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input decoded_op_t op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = lo[0];
      OP_LW, OP_SW:         is_misaligned = (lo != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_store_align.sv
// Store lane generation: byte enables and lane-replicated write data
// derived from the operation and the low address bits.
module store_align
  import dmem_access_pkg::*;
(
  input  decoded_op_t op,
  input  logic [1:0]  addr_lo,
  input  word_t       wdata,
  output logic [3:0]  wstrb,
  output word_t       lane_wdata
);

  always_comb begin
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    case (op)
      OP_SB: begin
        wstrb      = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      OP_SH: begin
        wstrb      = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
      end
      OP_SW: wstrb = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data memory access unit: drives an SRAM-like request/ack bus,
// one transaction at a time, and stalls the pipeline while it is busy.
module dmem_access
  import dmem_access_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  decoded_op_t in_op,
  input  word_t       in_addr,
  input  word_t       in_wdata,
  input  logic        flush,
  input  logic        out_ready,
  output logic        stall,
  output logic        out_valid,
  output word_t       out_rd,
  output logic        out_addr_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  decoded_op_t op_q, op_d;
  word_t       addr_q, addr_d;
  word_t       wdata_q, wdata_d;
  word_t       rd_q, rd_d;
  logic        cancel_q, cancel_d;

  logic in_mem;
  logic in_misaligned;
  logic accept;

  // Sub-word loads are shifted down to lane 0 here; extension happens in WB.
  function automatic word_t lane_rd(input decoded_op_t op, input logic [1:0] lo,
                                    input word_t rdata);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU: lane_rd = rdata >> {lo, 3'b000};
      default:                      lane_rd = rdata;
    endcase
  endfunction

  assign in_mem        = in_valid && is_mem_op(in_op) && !flush;
  assign in_misaligned = is_misaligned(in_op, in_addr[1:0]);
  assign accept        = (state_q == S_IDLE) && in_mem && !in_misaligned;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    cancel_d = cancel_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_ADDR;
          op_d     = in_op;
          addr_d   = in_addr;
          wdata_d  = in_wdata;
          cancel_d = 1'b0;
        end
      end
      S_ADDR: begin
        // Once the address is taken the bus owes us a data beat, so a
        // simultaneous flush has to ride through DATA as a cancel.
        if (data_addr_ok) begin
          state_d  = S_DATA;
          cancel_d = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (data_data_ok) begin
          if (cancel_q || flush) begin
            state_d  = S_IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = S_HOLD;
            rd_d    = lane_rd(op_q, addr_q[1:0], data_rdata);
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    stall        = 1'b0;
    out_valid    = 1'b0;
    out_addr_err = 1'b0;
    out_rd       = '0;
    if (resetn) begin
      case (state_q)
        S_IDLE: begin
          stall = accept;
          if (in_valid && !flush && !is_mem_op(in_op)) out_valid = 1'b1;
          if (in_mem && in_misaligned) begin
            out_valid    = 1'b1;
            out_addr_err = 1'b1;
          end
        end
        S_ADDR, S_DATA: stall = 1'b1;
        S_HOLD: begin
          out_valid = 1'b1;
          stall     = !out_ready;
          out_rd    = rd_q;
        end
        default: ;
      endcase
    end
  end

  // Request fields come straight from the latched copy so they stay stable
  // for however long the bus takes to accept the address.
  assign data_req  = resetn && (state_q == S_ADDR);
  assign data_addr = addr_q;
  assign data_size = op_size(op_q);
  assign data_wr   = is_store(op_q);

  store_align u_store_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .wstrb      (data_wstrb),
    .lane_wdata (data_wdata)
  );

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: scoreboard of expected WB results
// plus per-cycle bus and stall checks around each transaction.
`timescale 1ns/1ps
module tb_dmem_access;
  import dmem_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  decoded_op_t in_op = OP_NOP;
  word_t       in_addr = '0;
  word_t       in_wdata = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        stall;
  logic        out_valid;
  word_t       out_rd;
  logic        out_addr_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  dmem_access dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_op        (in_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .flush        (flush),
    .out_ready    (out_ready),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_rd       (out_rd),
    .out_addr_err (out_addr_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input decoded_op_t op, input word_t a, input word_t r);
    logic [31:0] sh;
    case (a[1:0])
      2'd0:    sh = r;
      2'd1:    sh = {8'h00, r[31:8]};
      2'd2:    sh = {16'h0000, r[31:16]};
      default: sh = {24'h000000, r[31:24]};
    endcase
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU: exp_rd = sh;
      OP_LW, OP_SB, OP_SH, OP_SW:   exp_rd = r;
      default:                      exp_rd = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wstrb(input decoded_op_t op, input word_t a);
    case (op)
      OP_SB: case (a[1:0])
               2'd0:    exp_wstrb = 32'h1;
               2'd1:    exp_wstrb = 32'h2;
               2'd2:    exp_wstrb = 32'h4;
               default: exp_wstrb = 32'h8;
             endcase
      OP_SH:   exp_wstrb = a[1] ? 32'hC : 32'h3;
      OP_SW:   exp_wstrb = 32'hF;
      default: exp_wstrb = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input decoded_op_t op, input word_t w);
    case (op)
      OP_SB:   exp_wdata = {w[7:0], w[7:0], w[7:0], w[7:0]};
      OP_SH:   exp_wdata = {w[15:0], w[15:0]};
      default: exp_wdata = w;
    endcase
  endfunction

  function automatic logic [31:0] exp_size(input decoded_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: exp_size = 32'd0;
      OP_LH, OP_LHU, OP_SH: exp_size = 32'd1;
      default:              exp_size = 32'd2;
    endcase
  endfunction

  function automatic logic [31:0] exp_wr(input decoded_op_t op);
    exp_wr = (op == OP_SB || op == OP_SH || op == OP_SW) ? 32'd1 : 32'd0;
  endfunction

  // WB-side scoreboard: every accepted result must match the head entry.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_out_rd", out_rd, e.rd);
        check_eq("sb_out_addr_err", 32'(out_addr_err), 32'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic mem_txn(input decoded_op_t op, input word_t addr, input word_t wdata,
                         input word_t rdata, input int addr_wait, input int data_wait,
                         input int ready_wait, input bit kill);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wdata;
    if (!kill) sb_q.push_back('{rd: exp_rd(op, addr, rdata), err: 1'b0});
    at_sample();
    check_eq("acc_stall", 32'(stall), 32'd1);
    check_eq("acc_req", 32'(data_req), 32'd0);
    check_eq("acc_valid", 32'(out_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;
    in_addr  = '0;
    in_wdata = '0;
    for (int i = 0; i <= addr_wait; i++) begin
      data_addr_ok = (i == addr_wait);
      at_sample();
      check_eq("addr_req", 32'(data_req), 32'd1);
      check_eq("addr_stall", 32'(stall), 32'd1);
      check_eq("addr_valid", 32'(out_valid), 32'd0);
      check_eq("addr_addr", data_addr, addr);
      check_eq("addr_size", 32'(data_size), exp_size(op));
      check_eq("addr_wr", 32'(data_wr), exp_wr(op));
      check_eq("addr_wstrb", 32'(data_wstrb), exp_wstrb(op, addr));
      if (exp_wr(op) != 0) check_eq("addr_wdata", data_wdata, exp_wdata(op, wdata));
      cyc();
    end
    data_addr_ok = 1'b0;
    for (int i = 0; i <= data_wait; i++) begin
      flush        = kill && (i == 0);
      data_data_ok = (i == data_wait);
      data_rdata   = (i == data_wait) ? rdata : $urandom;
      at_sample();
      check_eq("data_req", 32'(data_req), 32'd0);
      check_eq("data_stall", 32'(stall), 32'd1);
      check_eq("data_valid", 32'(out_valid), 32'd0);
      cyc();
    end
    flush        = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    if (kill) begin
      at_sample();
      check_eq("kill_valid", 32'(out_valid), 32'd0);
      check_eq("kill_stall", 32'(stall), 32'd0);
      check_eq("kill_req", 32'(data_req), 32'd0);
      cyc();
    end else begin
      for (int i = 0; i <= ready_wait; i++) begin
        out_ready = (i == ready_wait);
        at_sample();
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_stall", 32'(stall), (i == ready_wait) ? 32'd0 : 32'd1);
        check_eq("hold_req", 32'(data_req), 32'd0);
        cyc();
      end
      out_ready = 1'b1;
    end
  endtask

  task automatic misaligned(input decoded_op_t op, input word_t addr);
    in_valid = 1'b1;
    in_op    = op;
    in_addr  = addr;
    in_wdata = 32'h55AA55AA;
    sb_q.push_back('{rd: 32'h0, err: 1'b1});
    at_sample();
    check_eq("mis_valid", 32'(out_valid), 32'd1);
    check_eq("mis_err", 32'(out_addr_err), 32'd1);
    check_eq("mis_req", 32'(data_req), 32'd0);
    check_eq("mis_stall", 32'(stall), 32'd0);
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;
    at_sample();
    check_eq("mis_idle_req", 32'(data_req), 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    in_valid = 1'b1;
    in_op    = OP_LW;
    in_addr  = 32'h1000;
    repeat (2) cyc();
    at_sample();
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_err", 32'(out_addr_err), 32'd0);
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;
    in_addr  = '0;
    resetn   = 1'b1;
    at_sample();
    check_eq("rst_addr", data_addr, 32'h0);
    check_eq("rst_wstrb", 32'(data_wstrb), 32'h0);
    check_eq("rst_wr", 32'(data_wr), 32'd0);
    cyc();

    // Pass-through op: result in the same cycle, no bus traffic.
    in_valid = 1'b1;
    in_op    = OP_ADD;
    in_addr  = 32'h1003;
    sb_q.push_back('{rd: 32'h0, err: 1'b0});
    at_sample();
    check_eq("nonmem_valid", 32'(out_valid), 32'd1);
    check_eq("nonmem_stall", 32'(stall), 32'd0);
    check_eq("nonmem_req", 32'(data_req), 32'd0);
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;

    mem_txn(OP_LW,  32'h1000, 32'h0,        32'hDEADBEEF, 0, 0, 0, 1'b0);
    mem_txn(OP_LB,  32'h1003, 32'h0,        32'h80FF1234, 0, 0, 0, 1'b0);
    mem_txn(OP_SH,  32'h2002, 32'h0000ABCD, 32'h0,        0, 0, 0, 1'b0);
    mem_txn(OP_LHU, 32'h1002, 32'h0,        32'h80FF1234, 1, 2, 2, 1'b0);
    mem_txn(OP_SB,  32'h1001, 32'h12345678, 32'h5555AAAA, 0, 1, 0, 1'b0);
    mem_txn(OP_SW,  32'h3000, 32'hCAFEF00D, 32'h0,        2, 0, 1, 1'b0);
    mem_txn(OP_LH,  32'h1000, 32'h0,        32'h9876FEDC, 0, 0, 0, 1'b0);

    misaligned(OP_LW, 32'h1002);
    misaligned(OP_LH, 32'h1001);
    misaligned(OP_SW, 32'h2001);

    // Flush while waiting for data, then a normal load afterwards.
    mem_txn(OP_LW, 32'h1004, 32'h0, 32'h11112222, 0, 4, 0, 1'b1);
    mem_txn(OP_LW, 32'h1008, 32'h0, 32'h33334444, 0, 0, 0, 1'b0);

    // Flush in ADDR before the address is accepted.
    in_valid = 1'b1;
    in_op    = OP_SW;
    in_addr  = 32'h4000;
    in_wdata = 32'h01020304;
    at_sample();
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;
    flush    = 1'b1;
    at_sample();
    check_eq("fa_req", 32'(data_req), 32'd1);
    cyc();
    flush = 1'b0;
    at_sample();
    check_eq("fa_idle_req", 32'(data_req), 32'd0);
    check_eq("fa_idle_stall", 32'(stall), 32'd0);
    cyc();

    // Reset while the request is outstanding in ADDR.
    in_valid = 1'b1;
    in_op    = OP_LW;
    in_addr  = 32'h5000;
    at_sample();
    cyc();
    in_valid = 1'b0;
    in_op    = OP_NOP;
    in_addr  = '0;
    at_sample();
    check_eq("ra_req", 32'(data_req), 32'd1);
    cyc();
    resetn = 1'b0;
    at_sample();
    check_eq("ra_inrst_req", 32'(data_req), 32'd0);
    cyc();
    at_sample();
    check_eq("ra_req_after", 32'(data_req), 32'd0);
    check_eq("ra_stall", 32'(stall), 32'd0);
    check_eq("ra_valid", 32'(out_valid), 32'd0);
    check_eq("ra_err", 32'(out_addr_err), 32'd0);
    check_eq("ra_addr", data_addr, 32'h0);
    check_eq("ra_wstrb", 32'(data_wstrb), 32'h0);
    check_eq("ra_wdata", data_wdata, 32'h0);
    cyc();
    resetn = 1'b1;
    at_sample();
    check_eq("ra_idle_req", 32'(data_req), 32'd0);
    cyc();

    mem_txn(OP_LBU, 32'h6002, 32'h0, 32'hA1B2C3D4, 0, 0, 0, 1'b0);

    repeat (2) cyc();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 SHALL have these ports, each given as name, direction, width and meaning: clk, in, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have resetn, in, 1, reset; reset is synchronous and active-low.
REQ-003 SHALL have in_valid, in, 1, MEM stage holds a valid instruction.
REQ-004 SHALL have in_op, in, decoded_op_t, decoded operation; LB LBU LH LHU LW SB SH SW are memory ops, all others pass through.
REQ-005 SHALL have in_addr, in, word_t, byte effective address.
REQ-006 SHALL have in_wdata, in, word_t, store source register value.
REQ-007 SHALL have flush, in, 1, exception/eret kill of the MEM instruction.
REQ-008 SHALL have out_ready, in, 1, WB side accepts the result this cycle.
REQ-009 SHALL have stall, out, 1, hold all upstream pipeline registers.
REQ-010 SHALL have out_valid, out, 1, result available.
REQ-011 SHALL have out_rd, out, word_t, lane-aligned raw load word, fed to the sign/zero-extension stage.
REQ-012 SHALL have out_addr_err, out, 1, misaligned access (AdEL/AdES).
REQ-013 SHALL have data_req/data_wr, out, 1/1, SRAM-like request and write flag.
REQ-014 SHALL have data_size, out, 2, 0 byte, 1 half, 2 word.
REQ-015 SHALL have data_addr/data_wdata, out, 32/32, request address and write data.
REQ-016 SHALL have data_wstrb, out, 4, byte write enables.
REQ-017 SHALL have data_addr_ok/data_data_ok, in, 1/1, address accepted and data returned.
REQ-018 SHALL have data_rdata, in, 32, read data.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, HOLD; the op, addr and wdata SHALL be latched on leaving IDLE.
REQ-020 IDLE: in_valid & memory op & aligned & !flush SHALL go to ADDR; a non-memory op SHALL give out_valid=1 in the same cycle with no bus activity.
REQ-021 Misalignment SHALL be: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. In that case out_addr_err=1 and out_valid=1 in the same cycle, no request is issued, and the state stays IDLE.
REQ-022 ADDR: data_req SHALL be 1 and the request fields SHALL be stable; on data_addr_ok the FSM SHALL go to DATA, with data_req low in DATA.
REQ-023 DATA: data_data_ok SHALL be honoured only in DATA; on data_data_ok the FSM SHALL capture the read data and go to HOLD.
REQ-024 HOLD: out_valid SHALL be 1; out_ready SHALL return the FSM to IDLE.
REQ-025 Minimum latency SHALL be accept cycle to out_valid = 3 cycles, reached when addr_ok arrives in the first ADDR cycle and data_ok in the first DATA cycle.
REQ-026 stall SHALL be 1 when a memory op is accepted in IDLE, in ADDR, in DATA, and in HOLD while out_ready=0; it SHALL be 0 otherwise.
REQ-027 data_addr SHALL be the unmodified byte address; data_size SHALL be derived from op; data_wr SHALL be 1 for SB/SH/SW.
REQ-028 data_wstrb SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000.
REQ-029 data_wdata SHALL be: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-030 out_rd SHALL be: for LB/LBU/LH/LHU, data_rdata >> (8*addr[1:0]), zero-filled; for LW and stores, data_rdata unshifted; for non-memory ops, 0.
REQ-031 flush in ADDR before addr_ok SHALL drop data_req and go to IDLE; flush in the same cycle as addr_ok SHALL be treated as flush in DATA.
REQ-032 flush in DATA SHALL set a cancel flag; the FSM SHALL keep waiting for data_ok, discard the data, and return to IDLE without asserting out_valid.
REQ-033 flush in HOLD SHALL return the FSM to IDLE immediately.
REQ-034 At most one outstanding transaction SHALL exist; no new request SHALL be issued while in DATA.

Reset
REQ-035 resetn=0 at a clock edge SHALL force IDLE, cancel=0, and all latched fields to 0.
REQ-036 While in reset, data_req, stall, out_valid and out_addr_err SHALL all be 0.
REQ-037 Reset mid-transaction SHALL abandon the transaction without waiting for data_ok; the bus is reset by the same resetn.

Structure
REQ-038 word_t, decoded_op_t and the data_size encoding constants SHALL live in the shared CPU package; the FSM state enum SHALL be local.
REQ-039 The wstrb/wdata lane generation SHALL be one combinational sub-module, store_align.

Verification
REQ-040 LW addr 0x1000, addr_ok cycle 1, data_ok cycle 2, rdata 0xDEADBEEF -> out_rd 0xDEADBEEF, out_valid exactly 3 cycles after accept, stall high 3 cycles.
REQ-041 LB addr 0x1003, rdata 0x80FF_1234 -> out_rd 0x0000_0080, data_size 0, wstrb 0000.
REQ-042 SH addr 0x2002, wdata 0x0000_ABCD -> data_wdata 0xABCD_ABCD, wstrb 1100, data_size 1, data_wr 1.
REQ-043 LW addr 0x1002 -> out_addr_err 1 same cycle, data_req never asserts, stall 0.
REQ-044 LW with flush in DATA, data_ok 4 cycles later -> out_valid never asserts, return to IDLE the cycle after data_ok, next LW issues normally.
REQ-045 resetn low during ADDR -> data_req 0 next cycle, state IDLE, all outputs 0.
